alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Sequencer that shares the single 32-bit ALU between two requesters: port 0 (fetch/PC-update path) and port 1 (execute path) of the multi-cycle core. Accepts one operation at a time under a valid/ready handshake with round-robin grant, drives registered operands and opcode to the ALU, and captures the result and flags. Each result is held until the consumer accepts it.

## Interface
- `DATA_W`, default 32: operand and result width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  request pending on port 0 / port 1.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_x`, `req0_y`, `req1_x`, `req1_y`  in  DATA_W  operands.
- `req0_op`, `req1_op`  in  2  ALU opcode: 00 AND, 01 ADD, 10 SUB, 11 reserved.
- `alu_x`, `alu_y`  out  DATA_W  registered operands to ALU.
- `alu_op`  out  2  registered opcode to ALU.
- `alu_z`  in  DATA_W  ALU result.
- `alu_zero`, `alu_carry`  in  1  ALU ZeroFlag / CarryFlag.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  port that issued the response.
- `rsp_z`  out  DATA_W  captured result.
- `rsp_zero`, `rsp_carry`  out  1  captured flags.
- `rsp_err`  out  1  reserved-opcode error (see Configuration).

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any `reqN_valid`, grant one port and go to EXEC. Otherwise stay.
  - Grant rule: with one valid port, grant it. With both valid, grant the port not granted last (`last_grant` reset = 1, so port 0 wins the first tie).
  - `reqN_ready` = reset low AND state IDLE AND port N granted this cycle. It is combinational on valid. Exactly one ready is high per accept; none is high outside IDLE.
  - On accept: latch `reqN_x/y/op` into `alu_x/alu_y/alu_op`, latch N into `rsp_id` and `last_grant`.
- EXEC: the ALU settles combinationally on the registered inputs. At the end of the cycle, capture `alu_z`, `alu_zero`, `alu_carry` into `rsp_*`, assert `rsp_valid`, and go to RESP.
- RESP: hold `rsp_*` stable while `rsp_valid`=1. When `rsp_valid & rsp_ready` at an edge, clear `rsp_valid` and go to IDLE.
  - `rsp_z`/flags keep their last value after the handshake.
- Flags pass through unmodified. CarryFlag meaning is owned by the ALU; the arbiter does not interpret it.
- `alu_x/y/op` hold their last issued value outside EXEC.
- Requests that arrive while busy are not accepted. Requesters must hold valid and operands until ready.
- Reset mid-operation: any in-flight op is dropped with no response, and all registers return to reset values.

## Timing
- Reset values: `req0_ready`, `req1_ready`, `rsp_valid`, `rsp_id`, `rsp_zero`, `rsp_carry`, `rsp_err` = 0; `rsp_z`, `alu_x`, `alu_y` = 0; `alu_op` = 00.
- Accept at edge T:
  - `alu_*` valid after T.
  - Response captured at T+1; `rsp_valid` high after T+1.
- Minimum latency is 1 cycle from accept to `rsp_valid`.
- Minimum issue interval is 3 cycles (IDLE, EXEC, RESP with `rsp_ready` held high).
- `rsp_ready` low stalls indefinitely in RESP; no further accepts occur.
- Simultaneous valids in IDLE: the round-robin rule applies. Under a continuous two-port load, grants strictly alternate.

## Configuration
- `ALU_ARB_OPCHECK_EN` defined:
  - An opcode of 11 is accepted normally but not driven to the ALU (`alu_op` keeps its previous value).
  - In the next cycle, the response has `rsp_z`=0, `rsp_zero`=0, `rsp_carry`=0, `rsp_err`=1, with the same latency and handshake.
  - Legal opcodes give `rsp_err`=0.
- Undefined:
  - Opcode 11 is passed to the ALU unchanged and its outputs are captured as returned.
  - `rsp_err` is tied to 0.

## Test plan
- Port 0 only, x=AAAA5555, y=FFFF0000, op=00 → `req0_ready` in IDLE. One cycle later: `rsp_valid`=1, `rsp_id`=0, `rsp_z`=AAAA0000, `rsp_zero`=0.
- Port 1 only, ADD AAAA5555+11220000 → `rsp_z`=BBCC5555, `rsp_id`=1. Hold `rsp_ready`=0 for 5 cycles → outputs stable, `req*_ready` stay 0.
- Both ports valid continuously: port 0 SUB AAAAFFFF−AAAAFFFF, port 1 SUB AAAAFFFF−22223344 → grants 0,1,0,1. Port 0 responses give `rsp_z`=0, `rsp_zero`=1. Port 1 responses give `rsp_z`=8888CCBB.
- SUB AAAAFFFF−4512ACD2 → `rsp_z`=6598532D, and `rsp_carry` equals `alu_carry` as driven by the ALU (1).
- Assert `reset` during EXEC → all outputs immediately at reset values, no response. After release, a port 0 ADD 1+1 returns 00000002.
- Opcode 11 from port 0, x=5, y=3: with `ALU_ARB_OPCHECK_EN` → `rsp_err`=1, `rsp_z`=0. Without it → `alu_op`=11 driven, `rsp_err`=0.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response signals of the shared-ALU arbiter.
// The slave modport is the arbiter side; master is the requester/ALU/consumer side.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req0_valid;
  logic              req1_valid;
  logic              req0_ready;
  logic              req1_ready;
  logic [DATA_W-1:0] req0_x;
  logic [DATA_W-1:0] req0_y;
  logic [DATA_W-1:0] req1_x;
  logic [DATA_W-1:0] req1_y;
  logic [1:0]        req0_op;
  logic [1:0]        req1_op;
  logic [DATA_W-1:0] alu_x;
  logic [DATA_W-1:0] alu_y;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_z;
  logic              alu_zero;
  logic              alu_carry;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_z;
  logic              rsp_zero;
  logic              rsp_carry;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y, req0_op, req1_op,
    input  alu_z, alu_zero, alu_carry, rsp_ready,
    output req0_ready, req1_ready, alu_x, alu_y, alu_op,
    output rsp_valid, rsp_id, rsp_z, rsp_zero, rsp_carry, rsp_err
  );

  modport master (
    output req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y, req0_op, req1_op,
    output alu_z, alu_zero, alu_carry, rsp_ready,
    input  req0_ready, req1_ready, alu_x, alu_y, alu_op,
    input  rsp_valid, rsp_id, rsp_z, rsp_zero, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional macro ALU_ARB_OPCHECK_EN: trap reserved opcode 11 with rsp_err instead of issuing it.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input logic               clk,
  input logic               reset,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state;
  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic [DATA_W-1:0] sel_x;
  logic [DATA_W-1:0] sel_y;
  logic [1:0]        sel_op;
`ifdef ALU_ARB_OPCHECK_EN
  logic              op_err;
`endif

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    sel_x  = grant1 ? bus.req1_x  : bus.req0_x;
    sel_y  = grant1 ? bus.req1_y  : bus.req0_y;
    sel_op = grant1 ? bus.req1_op : bus.req0_op;
  end

  assign bus.req0_ready = ~reset & (state == StIdle) & grant0;
  assign bus.req1_ready = ~reset & (state == StIdle) & grant1;

`ifndef ALU_ARB_OPCHECK_EN
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      last_grant    <= 1'b1;
      bus.alu_x     <= '0;
      bus.alu_y     <= '0;
      bus.alu_op    <= 2'b00;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_z     <= '0;
      bus.rsp_zero  <= 1'b0;
      bus.rsp_carry <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      op_err        <= 1'b0;
      bus.rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (grant0 | grant1) begin
            bus.alu_x  <= sel_x;
            bus.alu_y  <= sel_y;
`ifdef ALU_ARB_OPCHECK_EN
            op_err     <= (sel_op == 2'b11);
            if (sel_op != 2'b11) bus.alu_op <= sel_op;
`else
            bus.alu_op <= sel_op;
`endif
            bus.rsp_id <= grant1;
            last_grant <= grant1;
            state      <= StExec;
          end
        end
        StExec: begin
          bus.rsp_valid <= 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
          bus.rsp_z     <= op_err ? '0 : bus.alu_z;
          bus.rsp_zero  <= ~op_err & bus.alu_zero;
          bus.rsp_carry <= ~op_err & bus.alu_carry;
          bus.rsp_err   <= op_err;
`else
          bus.rsp_z     <= bus.alu_z;
          bus.rsp_zero  <= bus.alu_zero;
          bus.rsp_carry <= bus.alu_carry;
`endif
          state         <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized bench for alu_share_arbiter with a transaction-level reference model.
// Honors ALU_ARB_OPCHECK_EN when defined for the build.
module tb_alu_share_arbiter;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_W(DATA_W)) bus ();

  alu_share_arbiter #(.DATA_W(DATA_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Simple ALU: carry is the carry-out of x + ~y + 1 for SUB; reserved op computes XOR.
  logic [DATA_W:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (bus.alu_op)
      2'b00:   alu_wide = {1'b0, bus.alu_x & bus.alu_y};
      2'b01:   alu_wide = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};
      2'b10:   alu_wide = {1'b0, bus.alu_x} + {1'b0, ~bus.alu_y} + 33'd1;
      default: alu_wide = {1'b0, bus.alu_x ^ bus.alu_y};
    endcase
  end
  assign bus.alu_z     = alu_wide[DATA_W-1:0];
  assign bus.alu_carry = alu_wide[DATA_W];
  assign bus.alu_zero  = (alu_wide[DATA_W-1:0] == '0);

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one transaction in flight, response becomes visible one cycle after accept.
  bit          m_busy, m_shown, m_last, m_rsp_valid, m_id, m_zero, m_carry, m_err;
  logic [31:0] m_z, m_ax, m_ay;
  logic [1:0]  m_aop;
  logic [31:0] p_z;
  bit          p_zero, p_carry, p_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0; m_shown = 0; m_last = 1; m_rsp_valid = 0; m_id = 0;
    m_zero = 0; m_carry = 0; m_err = 0; m_z = '0; m_ax = '0; m_ay = '0; m_aop = 2'b00;
  endfunction

  function automatic void ref_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op,
                                 output logic [31:0] z, output bit c, output bit e);
    longint unsigned lx = 64'(x);
    longint unsigned ly = 64'(y);
    c = 0;
    e = 0;
    case (op)
      2'b00: z = x & y;
      2'b01: begin z = 32'(lx + ly); c = (lx + ly) > 64'hFFFF_FFFF; end
      2'b10: begin z = 32'(lx - ly); c = (lx >= ly); end
      default: begin
`ifdef ALU_ARB_OPCHECK_EN
        z = '0; e = 1;
`else
        z = x ^ y;
`endif
      end
    endcase
  endfunction

  // One clock cycle: drive at negedge, compare against the model, then advance the model.
  task automatic step(input bit v0, input logic [31:0] x0, input logic [31:0] y0,
                      input logic [1:0] op0, input bit v1, input logic [31:0] x1,
                      input logic [31:0] y1, input logic [1:0] op1, input bit rr,
                      output int granted);
    bit e0, e1, g;
    logic [1:0] op;
    granted = -1;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_x = x0; bus.req0_y = y0; bus.req0_op = op0;
    bus.req1_valid = v1; bus.req1_x = x1; bus.req1_y = y1; bus.req1_op = op1;
    bus.rsp_ready  = rr;
    #1;
    e0 = !m_busy && v0 && (!v1 || m_last);
    e1 = !m_busy && v1 && (!v0 || !m_last);
    check("req0_ready", 32'(bus.req0_ready), 32'(e0));
    check("req1_ready", 32'(bus.req1_ready), 32'(e1));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
    check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
    check("rsp_z", bus.rsp_z, m_z);
    check("rsp_zero", 32'(bus.rsp_zero), 32'(m_zero));
    check("rsp_carry", 32'(bus.rsp_carry), 32'(m_carry));
    check("rsp_err", 32'(bus.rsp_err), 32'(m_err));
    check("alu_x", bus.alu_x, m_ax);
    check("alu_y", bus.alu_y, m_ay);
    check("alu_op", 32'(bus.alu_op), 32'(m_aop));
    if (!m_busy) begin
      if (e0 || e1) begin
        g = e1;
        granted = int'(g);
        m_id = g; m_last = g;
        m_ax = g ? x1 : x0;
        m_ay = g ? y1 : y0;
        op   = g ? op1 : op0;
`ifdef ALU_ARB_OPCHECK_EN
        if (op != 2'b11) m_aop = op;
`else
        m_aop = op;
`endif
        ref_op(m_ax, m_ay, op, p_z, p_carry, p_err);
        p_zero = !p_err && (p_z == '0);
        m_busy = 1; m_shown = 0;
      end
    end else if (!m_shown) begin
      m_rsp_valid = 1; m_shown = 1;
      m_z = p_z; m_zero = p_zero; m_carry = p_carry; m_err = p_err;
    end else if (rr) begin
      m_rsp_valid = 0; m_busy = 0;
    end
    @(posedge clk);
  endtask

  task automatic idle(input bit rr, input int n);
    int g;
    for (int i = 0; i < n; i++) step(0, '0, '0, 2'b00, 0, '0, '0, 2'b00, rr, g);
  endtask

  // Asynchronous reset mid-cycle; every output must drop to its reset value at once.
  task automatic do_reset(input bit vhold);
    @(negedge clk);
    bus.req0_valid = vhold;
    bus.req1_valid = vhold;
    reset = 1'b1;
    #1;
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_z", bus.rsp_z, 32'd0);
    check("rst_flags", {29'd0, bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 32'd0);
    check("rst_alu_xy", bus.alu_x | bus.alu_y, 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    model_reset();
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int g, prev;
    bit          pv[2];
    logic [31:0] px[2], py[2];
    logic [1:0]  pop[2];
    bit          rr;

    bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 0;
    bus.req0_x = '0; bus.req0_y = '0; bus.req0_op = '0;
    bus.req1_x = '0; bus.req1_y = '0; bus.req1_op = '0;
    model_reset();
    do_reset(1'b0);

    // Port 0 AND
    step(1, 32'hAAAA5555, 32'hFFFF0000, 2'b00, 0, '0, '0, 2'b00, 1, g);
    check("t1_grant", 32'(g), 32'd0);
    idle(0, 1);
    #1;
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t1_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("t1_rsp_z", bus.rsp_z, 32'hAAAA0000);
    check("t1_rsp_zero", 32'(bus.rsp_zero), 32'd0);
    idle(1, 1);

    // Port 1 ADD, then a 5-cycle consumer stall with port 0 waiting
    step(0, '0, '0, 2'b00, 1, 32'hAAAA5555, 32'h11220000, 2'b01, 0, g);
    check("t2_grant", 32'(g), 32'd1);
    idle(0, 1);
    #1;
    check("t2_rsp_z", bus.rsp_z, 32'hBBCC5555);
    check("t2_rsp_id", 32'(bus.rsp_id), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h1, 32'h3, 2'b00, 0, '0, '0, 2'b00, 0, g);
      check("t2_stall_noacc", 32'(g), 32'hFFFFFFFF);
    end
    #1;
    check("t2_stall_rsp_z", bus.rsp_z, 32'hBBCC5555);
    step(1, 32'h1, 32'h3, 2'b00, 0, '0, '0, 2'b00, 1, g);
    step(1, 32'h1, 32'h3, 2'b00, 0, '0, '0, 2'b00, 1, g);
    check("t2_late_grant", 32'(g), 32'd0);
    idle(1, 2);

    // Continuous two-port SUB load from reset: grants alternate 0,1,0,1
    do_reset(1'b0);
    prev = 1;
    for (int k = 0; k < 4; k++) begin
      step(1, 32'hAAAAFFFF, 32'hAAAAFFFF, 2'b10, 1, 32'hAAAAFFFF, 32'h22223344, 2'b10, 1, g);
      check("t3_alternate", 32'(g), 32'(prev ^ 1));
      prev = g;
      step(1, 32'hAAAAFFFF, 32'hAAAAFFFF, 2'b10, 1, 32'hAAAAFFFF, 32'h22223344, 2'b10, 1, g);
      #1;
      check("t3_rsp_z", bus.rsp_z, (prev == 1) ? 32'h8888CCBB : 32'h0);
      check("t3_rsp_zero", 32'(bus.rsp_zero), (prev == 1) ? 32'd0 : 32'd1);
      step(1, 32'hAAAAFFFF, 32'hAAAAFFFF, 2'b10, 1, 32'hAAAAFFFF, 32'h22223344, 2'b10, 1, g);
    end
    idle(1, 1);

    // SUB with no borrow: carry comes straight from the ALU
    step(1, 32'hAAAAFFFF, 32'h4512ACD2, 2'b10, 0, '0, '0, 2'b00, 1, g);
    idle(0, 1);
    #1;
    check("t4_rsp_z", bus.rsp_z, 32'h6598532D);
    check("t4_rsp_carry", 32'(bus.rsp_carry), 32'd1);
    idle(1, 1);

    // Reset during EXEC drops the op; then ADD 1+1
    step(1, 32'h7, 32'h9, 2'b01, 0, '0, '0, 2'b00, 1, g);
    do_reset(1'b1);
    step(1, 32'h1, 32'h1, 2'b01, 0, '0, '0, 2'b00, 1, g);
    check("t5_grant", 32'(g), 32'd0);
    idle(0, 1);
    #1;
    check("t5_rsp_z", bus.rsp_z, 32'h00000002);
    idle(1, 1);

    // Reserved opcode
    step(1, 32'h5, 32'h3, 2'b11, 0, '0, '0, 2'b00, 1, g);
    idle(0, 1);
    #1;
`ifdef ALU_ARB_OPCHECK_EN
    check("t6_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("t6_rsp_z", bus.rsp_z, 32'd0);
`else
    check("t6_alu_op", 32'(bus.alu_op), 32'd3);
    check("t6_rsp_err", 32'(bus.rsp_err), 32'd0);
`endif
    idle(1, 1);

    // Random traffic: requesters hold each request until it is granted
    pv[0] = 0; pv[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 2) == 0) begin
          pv[p]  = 1;
          px[p]  = $urandom();
          py[p]  = ($urandom_range(0, 7) == 0) ? px[p] : $urandom();
          pop[p] = 2'($urandom_range(0, 3));
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1'b1);
      end else begin
        step(pv[0], px[0], py[0], pop[0], pv[1], px[1], py[1], pop[1], rr, g);
        if (g >= 0) pv[g] = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
